// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache between the MEM stage and word-addressed DataMemory.
// Hit: 1 cycle, clean miss: 6, dirty miss: 10; req_ready is high only in IDLE, one request per 2 cycles max.
module dcache_controller #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_din,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_dout,
  output logic        resp_hit,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int IDX_LSB  = 2 + OFFSET_W;
  localparam int TAG_LSB  = IDX_LSB + INDEX_W;
  localparam int TAG_W    = 32 - TAG_LSB;
  localparam int SEL_W    = INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_FILL} state_t;

  state_t              r_state;
  logic [OFFSET_W-1:0] r_cnt;
  logic                r_write;
  logic [31:2]         r_addr;
  logic [31:0]         r_din;
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [31:0]         r_data [NUM_SETS*LINE_WORDS];

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_dout;
  logic        r_resp_hit;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_mem_read;
  logic        r_mem_write;

  logic [INDEX_W-1:0]  w_idx, w_in_idx;
  logic [OFFSET_W-1:0] w_off, w_in_off, w_cnt_nxt;
  logic [TAG_W-1:0]    w_tag, w_in_tag;
  logic                w_hit, w_in_hit, w_cnt_last;
  logic [31:0]         w_in_rd, w_wb_nxt, w_wb_first, w_line_rd;
  logic                w_data_we;
  logic [SEL_W-1:0]    w_data_sel;
  logic [31:0]         w_data_wdat;
  logic                w_unused;

  assign w_unused   = ^req_addr[1:0];
  assign w_idx      = r_addr[TAG_LSB-1:IDX_LSB];
  assign w_off      = r_addr[IDX_LSB-1:2];
  assign w_tag      = r_addr[31:TAG_LSB];
  assign w_in_idx   = req_addr[TAG_LSB-1:IDX_LSB];
  assign w_in_off   = req_addr[IDX_LSB-1:2];
  assign w_in_tag   = req_addr[31:TAG_LSB];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_in_hit   = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
  assign w_cnt_nxt  = r_cnt + OFFSET_W'(1);
  assign w_cnt_last = (r_cnt == OFFSET_W'(LINE_WORDS - 1));
  assign w_in_rd    = r_data[{w_in_idx, w_in_off}];
  assign w_wb_nxt   = r_data[{w_idx, w_cnt_nxt}];
  assign w_wb_first = r_data[{w_idx, {OFFSET_W{1'b0}}}];
  assign w_line_rd  = r_data[{w_idx, w_off}];

  // Data array has no reset; a store hit in COMPARE and each FILL beat are its only writers.
  always_comb begin
    w_data_we   = 1'b0;
    w_data_sel  = {w_idx, w_off};
    w_data_wdat = r_din;
    if (!reset) begin
      if (r_state == S_COMPARE && w_hit && r_write) begin
        w_data_we = 1'b1;
      end else if (r_state == S_FILL) begin
        w_data_we   = 1'b1;
        w_data_sel  = {w_idx, r_cnt};
        w_data_wdat = mem_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_data_we) r_data[w_data_sel] <= w_data_wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_dout  <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_dout  <= '0;
      r_resp_hit   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr[31:2];
            r_din       <= req_din;
            r_req_ready <= 1'b0;
            r_state     <= S_COMPARE;
            // Lookup is done on the incoming address so the hit response is registered into COMPARE.
            r_resp_valid <= w_in_hit;
            r_resp_hit   <= w_in_hit;
            r_resp_dout  <= (w_in_hit && !req_write) ? w_in_rd : '0;
          end
        end
        S_COMPARE: begin
          r_cnt <= '0;
          if (w_hit) begin
            if (r_write) r_dirty[w_idx] <= 1'b1;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
            r_state     <= S_WRITEBACK;
            r_mem_write <= 1'b1;
            r_mem_addr  <= {r_tag[w_idx], w_idx, {OFFSET_W{1'b0}}, 2'b00};
            r_mem_din   <= w_wb_first;
          end else begin
            r_state    <= S_FILL;
            r_mem_read <= 1'b1;
            r_mem_addr <= {w_tag, w_idx, {OFFSET_W{1'b0}}, 2'b00};
          end
        end
        S_WRITEBACK: begin
          if (w_cnt_last) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_FILL;
            r_cnt          <= '0;
            r_mem_write    <= 1'b0;
            r_mem_read     <= 1'b1;
            r_mem_addr     <= {w_tag, w_idx, {OFFSET_W{1'b0}}, 2'b00};
            r_mem_din      <= '0;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= {r_tag[w_idx], w_idx, w_cnt_nxt, 2'b00};
            r_mem_din  <= w_wb_nxt;
          end
        end
        S_FILL: begin
          if (w_cnt_last) begin
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_COMPARE;
            r_cnt          <= '0;
            r_mem_read     <= 1'b0;
            r_mem_addr     <= '0;
            // The requested word may be the one arriving on this very edge.
            r_resp_valid   <= 1'b1;
            r_resp_hit     <= 1'b0;
            if (!r_write) r_resp_dout <= (w_off == r_cnt) ? mem_dout : w_line_rd;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= {w_tag, w_idx, w_cnt_nxt, 2'b00};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_dout  = r_resp_dout;
  assign resp_hit   = r_resp_hit;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_read   = r_mem_read & ~reset;
  assign mem_write  = r_mem_write & ~reset;

endmodule
